// File: rtl/sdram_read_fifo.sv
// sdram_read_fifo: single-clock buffer between the SDRAM read engine and the
// wishbone read path. Early full leaves FULL_MARGIN entries free so the
// engine's in-flight words still land after it samples full.
module sdram_read_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int FULL_LEVEL_INT = DEPTH - FULL_MARGIN;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = FULL_LEVEL_INT[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_accept;
  logic rd_accept;

  // Acceptance uses the pre-cycle count only: a same-cycle read never frees
  // space for a write, and a same-cycle write never feeds a read.
  assign wr_accept = wr_en && (count_q != DEPTH_CNT) && !clear;
  assign rd_accept = rd_en && (count_q != '0) && !clear;

  // Next-state for pointers, occupancy, read port and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else if (wr_en) begin
        overflow_d = 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
      end else if (rd_en) begin
        underflow_d = 1'b1;
      end
      if (wr_accept && !rd_accept) begin
        count_d = count_q + 1'b1;
      end else if (rd_accept && !wr_accept) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Control and read-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q >= FULL_LEVEL);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
